// File: rtl/mio_cli_cmd_arb.sv
// mio_cli_cmd_arb
// Round-robin arbiter that lets NUM_REQ requesters share one command/response
// channel. Only one transaction is ever outstanding. The winning request is
// captured, issued until the channel accepts it, and the response is then
// routed back one-hot to the requester that issued it.
//
// Optional feature: define MIO_CLI_ARB_TIMEOUT_EN to add a response timeout.
// When a response does not arrive within TIMEOUT_CYCLES cycles of WAIT_RSP,
// the requester receives an error completion (req_rsp_err=1, data 0).
// Without the macro, WAIT_RSP waits forever and req_rsp_err is tied low.
//
// Ports
//   clk            sole clock, rising edge
//   reset          asynchronous, active-high reset
//   req_valid      per-requester command pending
//   req_ready      per-requester grant (combinational, IDLE only)
//   req_data       requester i payload at [i*DATA_W +: DATA_W]
//   cmd_valid      command to shared channel valid
//   cmd_ready      shared channel accepts command
//   cmd_data       granted command payload
//   cmd_id         granted requester index
//   rsp_valid      shared channel response strobe
//   rsp_data       response payload
//   req_rsp_valid  one-hot response delivery (one cycle)
//   req_rsp_data   delivered response payload (held between deliveries)
//   req_rsp_err    delivered response is a timeout
//   busy           transaction in flight
//
// state    | meaning
// IDLE     | no transaction; grant offered combinationally to one requester
// ISSUE    | captured command presented on cmd_* until cmd_ready
// WAIT_RSP | command accepted; waiting for rsp_valid (or timeout)
module mio_cli_cmd_arb #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [DATA_W-1:0]          cmd_data,
    output logic [$clog2(NUM_REQ)-1:0] cmd_id,
    input  logic                       rsp_valid,
    input  logic [DATA_W-1:0]          rsp_data,
    output logic [NUM_REQ-1:0]         req_rsp_valid,
    output logic [DATA_W-1:0]          req_rsp_data,
    output logic                       req_rsp_err,
    output logic                       busy
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t             r_state;
    logic [IW-1:0]      r_last_grant;
    logic [IW-1:0]      r_cmd_id;
    logic [DATA_W-1:0]  r_cmd_data;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;

    logic               w_grant_any;
    logic [IW-1:0]      w_grant_idx;
    logic [IW-1:0]      w_scan_idx;

`ifdef MIO_CLI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] r_to_cnt;
    logic          r_rsp_err;
    logic          w_to_hit;

    // Counter starts at 0 on WAIT_RSP entry, so the limit is reached on the
    // TIMEOUT_CYCLES-th WAIT_RSP cycle.
    assign w_to_hit    = (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign req_rsp_err = r_rsp_err;
`else
    assign req_rsp_err = 1'b0;
`endif

    // Scan from the farthest offset down to the nearest one so that the
    // requester closest after last_grant overwrites earlier candidates.
    // Offset NUM_REQ is last_grant itself, i.e. lowest priority.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_scan_idx = IW'((int'(r_last_grant) + k) % NUM_REQ);
            if (req_valid[w_scan_idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
    end

    assign req_ready = (r_state == IDLE && w_grant_any) ?
                       (NUM_REQ'(1) << w_grant_idx) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= IW'(NUM_REQ - 1);
            r_cmd_data   <= '0;
            r_cmd_id     <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
`ifdef MIO_CLI_ARB_TIMEOUT_EN
            r_to_cnt     <= '0;
            r_rsp_err    <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_grant_any) begin
                        r_cmd_data <= req_data[int'(w_grant_idx)*DATA_W +: DATA_W];
                        r_cmd_id   <= w_grant_idx;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        r_state  <= WAIT_RSP;
`ifdef MIO_CLI_ARB_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
                end
                WAIT_RSP: begin
                    // A real response beats a timeout landing in the same cycle.
                    if (rsp_valid) begin
                        r_rsp_valid  <= NUM_REQ'(1) << r_cmd_id;
                        r_rsp_data   <= rsp_data;
                        r_last_grant <= r_cmd_id;
                        r_state      <= IDLE;
`ifdef MIO_CLI_ARB_TIMEOUT_EN
                        r_rsp_err    <= 1'b0;
                    end else if (w_to_hit) begin
                        r_rsp_valid  <= NUM_REQ'(1) << r_cmd_id;
                        r_rsp_data   <= '0;
                        r_rsp_err    <= 1'b1;
                        r_last_grant <= r_cmd_id;
                        r_state      <= IDLE;
                    end else begin
                        r_to_cnt     <= r_to_cnt + CW'(1);
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_valid     = (r_state == ISSUE);
    assign cmd_data      = r_cmd_data;
    assign cmd_id        = r_cmd_id;
    assign req_rsp_valid = r_rsp_valid;
    assign req_rsp_data  = r_rsp_data;
    assign busy          = (r_state != IDLE);

endmodule
